// File: rtl/osf_stream_capture.sv
// Capture engine for the oversample-filter stream. It selects one channel,
// decimates its valid samples, and stores the kept words in a first-word-
// fall-through FIFO. Capture runs continuously (mode 0) or stops after one
// block (mode 1). Any change of channel or mode flushes the FIFO and the
// capture state.
module osf_stream_capture #(
  parameter int N_CH   = 8,
  parameter int W_DATA = 18,
  parameter int W_OUT  = 16,
  parameter int DEPTH  = 1024,
  parameter int W_DEC  = 16,
  parameter int W_CNT  = $clog2(DEPTH) + 1
) (
  input  logic                     clk50_in,
  input  logic                     sys_reset_out,
  input  logic [N_CH-1:0]          data_valid_in,
  input  logic [N_CH*W_DATA-1:0]   data_packed_in,
  input  logic [$clog2(N_CH)-1:0]  chan_sel_in,
  input  logic                     mode_in,
  input  logic [W_DEC-1:0]         decim_in,
  input  logic [W_CNT-1:0]         block_len_in,
  input  logic                     arm_in,
  input  logic                     rd_en_in,
  output logic [W_OUT-1:0]         data_out,
  output logic                     empty_out,
  output logic [W_CNT-1:0]         fill_out,
  output logic                     overflow_out,
  output logic                     done_out,
  output logic                     busy_out
);

  localparam int W_SEL  = $clog2(N_CH);
  localparam int W_ADDR = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

  state_t state_reg, state_next;

  logic [W_DATA-1:0] chan_data [N_CH];
  logic [W_DATA-1:0] sel_sample;
  logic              sel_valid_reg;
  logic [W_OUT-1:0]  sel_data_reg;
  logic [W_SEL-1:0]  chan_prev_reg;
  logic              mode_prev_reg;

  logic [W_DEC-1:0]  dcnt_reg;
  logic [W_CNT-1:0]  blk_reg;
  logic              overflow_reg;

  logic [W_CNT-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [W_ADDR-1:0] rd_addr_next;
  logic [W_OUT-1:0]  mem [DEPTH];
  logic [W_OUT-1:0]  ram_q_reg;
  logic              bypass_reg;
  logic [W_OUT-1:0]  bypass_data_reg;

  logic              flush, empty, full, keep, push, pop, drop, blk_hit;
  logic [W_CNT-1:0]  blk_target;
  logic [W_CNT:0]    blk_inc;

  // Unpack the per-channel samples so the channel mux is a plain array index.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign chan_data[gi] = data_packed_in[gi*W_DATA +: W_DATA];
    end
  endgenerate

  assign sel_sample = chan_data[chan_sel_in];

  // A change of channel or mode relative to last cycle flushes everything.
  assign flush = (chan_sel_in != chan_prev_reg) || (mode_in != mode_prev_reg);

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {W_ADDR{1'b0}}});

  assign keep = (state_reg == ST_CAPTURE) && sel_valid_reg && (dcnt_reg == '0);
  assign pop  = rd_en_in && !empty && !flush;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a word.
  assign push = keep && (!full || pop) && !flush;
  assign drop = keep && full && !pop && !flush;

  assign blk_target = (block_len_in == '0) ? W_CNT'(DEPTH) : block_len_in;
  assign blk_inc    = {1'b0, blk_reg} + 1'b1;
  // Greater-or-equal guards against block_len_in being lowered mid-block.
  assign blk_hit    = (blk_inc >= {1'b0, blk_target});

  assign rd_ptr_next  = flush ? '0 : (pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg);
  assign rd_addr_next = rd_ptr_next[W_ADDR-1:0];

  // Register the selected valid/sample and the channel/mode for change detection.
  always_ff @(posedge clk50_in or posedge sys_reset_out) begin
    if (sys_reset_out) begin
      sel_valid_reg <= 1'b0;
      sel_data_reg  <= '0;
      chan_prev_reg <= '0;
      mode_prev_reg <= 1'b0;
    end else begin
      sel_valid_reg <= data_valid_in[chan_sel_in];
      sel_data_reg  <= sel_sample[W_DATA-1 -: W_OUT];
      chan_prev_reg <= chan_sel_in;
      mode_prev_reg <= mode_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk50_in or posedge sys_reset_out) begin
    if (sys_reset_out) state_reg <= ST_IDLE;
    else               state_reg <= state_next;
  end

  // Next-state logic; arm always (re)enters CAPTURE, flush overrides all.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (arm_in) state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (arm_in)                         state_next = ST_CAPTURE;
        else if (mode_in && push && blk_hit) state_next = ST_DONE;
      end
      ST_DONE:    if (arm_in) state_next = ST_CAPTURE;
      default:    state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Decimation counter, block counter and sticky overflow flag.
  always_ff @(posedge clk50_in or posedge sys_reset_out) begin
    if (sys_reset_out) begin
      dcnt_reg     <= '0;
      blk_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (flush || arm_in) begin
      dcnt_reg     <= '0;
      blk_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_CAPTURE) && sel_valid_reg)
        dcnt_reg <= (dcnt_reg == decim_in) ? '0 : dcnt_reg + 1'b1;
      if (push && mode_in)
        blk_reg <= blk_inc[W_CNT-1:0];
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  // FIFO pointers; flush empties the FIFO by collapsing both pointers.
  always_ff @(posedge clk50_in or posedge sys_reset_out) begin
    if (sys_reset_out) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (flush)     wr_ptr_reg <= '0;
      else if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage array write and registered look-ahead read of the next head word.
  always_ff @(posedge clk50_in) begin
    if (push) mem[wr_ptr_reg[W_ADDR-1:0]] <= sel_data_reg;
    ram_q_reg <= mem[rd_addr_next];
  end

  // Bypass path for a word written to the slot that becomes the head.
  always_ff @(posedge clk50_in) begin
    bypass_reg      <= push && (wr_ptr_reg[W_ADDR-1:0] == rd_addr_next);
    bypass_data_reg <= sel_data_reg;
  end

  assign empty_out    = empty;
  assign data_out     = empty ? '0 : (bypass_reg ? bypass_data_reg : ram_q_reg);
  assign fill_out     = wr_ptr_reg - rd_ptr_reg;
  assign overflow_out = overflow_reg;
  assign done_out     = (state_reg == ST_DONE);
  assign busy_out     = (state_reg == ST_CAPTURE);

endmodule

// File: tb/tb_osf_stream_capture.sv
// Scoreboard bench for osf_stream_capture with a 16-word FIFO: stimulus
// pushes expected words, a negedge monitor compares each popped word.
module tb_osf_stream_capture;

  localparam int N_CH   = 8;
  localparam int W_DATA = 18;
  localparam int W_OUT  = 16;
  localparam int DEPTH  = 16;
  localparam int W_DEC  = 16;
  localparam int W_CNT  = 5;

  logic                   clk50_in = 1'b0;
  logic                   sys_reset_out = 1'b0;
  logic [N_CH-1:0]        data_valid_in = '0;
  logic [N_CH*W_DATA-1:0] data_packed_in = '0;
  logic [2:0]             chan_sel_in = 3'd3;
  logic                   mode_in = 1'b0;
  logic [W_DEC-1:0]       decim_in = '0;
  logic [W_CNT-1:0]       block_len_in = '0;
  logic                   arm_in = 1'b0;
  logic                   rd_en_in = 1'b0;
  logic [W_OUT-1:0]       data_out;
  logic                   empty_out;
  logic [W_CNT-1:0]       fill_out;
  logic                   overflow_out;
  logic                   done_out;
  logic                   busy_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  osf_stream_capture #(
    .N_CH(N_CH), .W_DATA(W_DATA), .W_OUT(W_OUT),
    .DEPTH(DEPTH), .W_DEC(W_DEC), .W_CNT(W_CNT)
  ) dut (
    .clk50_in(clk50_in), .sys_reset_out(sys_reset_out),
    .data_valid_in(data_valid_in), .data_packed_in(data_packed_in),
    .chan_sel_in(chan_sel_in), .mode_in(mode_in), .decim_in(decim_in),
    .block_len_in(block_len_in), .arm_in(arm_in), .rd_en_in(rd_en_in),
    .data_out(data_out), .empty_out(empty_out), .fill_out(fill_out),
    .overflow_out(overflow_out), .done_out(done_out), .busy_out(busy_out)
  );

  always #5 clk50_in = ~clk50_in;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk50_in);
    #1;
  endtask

  // One valid cycle: target channel gets val, all others get random noise.
  task automatic drive_sample(input int ch, input logic [17:0] val);
    for (int k = 0; k < N_CH; k++)
      data_packed_in[k*W_DATA +: W_DATA] = (k == ch) ? val : 18'($urandom);
    data_valid_in = '1;
    tick();
  endtask

  task automatic end_samples();
    data_valid_in = '0;
    repeat (3) tick();
  endtask

  task automatic arm();
    arm_in = 1'b1;
    tick();
    arm_in = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_en_in = 1'b1;
    for (int i = 0; i < 40 && !empty_out; i++) tick();
    rd_en_in = 1'b0;
    chk({name, "_empty"}, int'(empty_out), 1);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  // Monitor: every pop presented to the DUT is checked against the scoreboard.
  always @(negedge clk50_in) begin : monitor
    logic [15:0] e;
    if (rd_en_in && !empty_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_data: got 0x%0h, expected no word", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("read_data", int'(data_out), int'(e));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state
    #2 sys_reset_out = 1'b1;
    repeat (2) tick();
    chk("rst_data", int'(data_out), 0);
    chk("rst_empty", int'(empty_out), 1);
    chk("rst_fill", int'(fill_out), 0);
    chk("rst_ovf", int'(overflow_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    sys_reset_out = 1'b0;
    repeat (3) tick();

    // ---- 1: continuous, channel 3, no decimation
    arm();
    chk("s1_busy", int'(busy_out), 1);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'hFFFF - 16'(i));
      drive_sample(3, {16'hFFFF - 16'(i), 2'b11});
    end
    end_samples();
    chk("s1_fill", int'(fill_out), 10);
    chk("s1_head", int'(data_out), 16'hFFFF);
    drain("s1");

    // ---- 2: block of 5, keep 1 of 3
    mode_in = 1'b1; block_len_in = 5'd5; decim_in = 16'd2;
    repeat (2) tick();
    chk("s2_flush_busy", int'(busy_out), 0);
    arm();
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 3 || i == 6 || i == 9 || i == 12)
        exp_q.push_back(16'h4000 + 16'(i));
      drive_sample(3, {16'h4000 + 16'(i), 2'b01});
    end
    end_samples();
    chk("s2_done", int'(done_out), 1);
    chk("s2_busy", int'(busy_out), 0);
    chk("s2_fill", int'(fill_out), 5);
    chk("s2_ovf", int'(overflow_out), 0);
    drain("s2");
    chk("s2_done_hold", int'(done_out), 1);

    // ---- 3: continuous overflow with 20 kept samples
    mode_in = 1'b0; decim_in = '0; block_len_in = '0;
    repeat (2) tick();
    arm();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back(16'h1000 + 16'(i));
      drive_sample(3, {16'h1000 + 16'(i), 2'b10});
    end
    end_samples();
    chk("s3_fill", int'(fill_out), 16);
    chk("s3_ovf", int'(overflow_out), 1);
    arm();
    chk("s3_rearm_ovf", int'(overflow_out), 0);
    chk("s3_rearm_busy", int'(busy_out), 1);
    chk("s3_rearm_fill", int'(fill_out), 16);

    // ---- 4: full FIFO, pop and write on the same edge
    exp_q.push_back(16'h2000);
    drive_sample(3, {16'h2000, 2'b00});
    data_valid_in = '0;
    rd_en_in = 1'b1;
    tick();
    rd_en_in = 1'b0;
    chk("s4_fill", int'(fill_out), 16);
    chk("s4_ovf", int'(overflow_out), 0);
    tick();
    chk("s4_fill_after", int'(fill_out), 16);
    drain("s4");

    // ---- 5: channel change with 7 words stored
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(16'h3000 + 16'(i));
      drive_sample(3, {16'h3000 + 16'(i), 2'b11});
    end
    end_samples();
    chk("s5_fill", int'(fill_out), 7);
    chk_sel_change: begin
      chan_sel_in = 3'd5;
      exp_q.delete();
      tick();
    end
    chk("s5_flush_fill", int'(fill_out), 0);
    chk("s5_flush_empty", int'(empty_out), 1);
    chk("s5_flush_busy", int'(busy_out), 0);
    tick();
    arm();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'h5000 + 16'(i));
      drive_sample(5, {16'h5000 + 16'(i), 2'b01});
    end
    end_samples();
    chk("s5_new_fill", int'(fill_out), 3);
    chk("s5_new_busy", int'(busy_out), 1);
    drain("s5");

    // ---- 6: asynchronous reset mid-block
    mode_in = 1'b1; block_len_in = 5'd8;
    repeat (2) tick();
    arm();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'h6000 + 16'(i));
      drive_sample(5, {16'h6000 + 16'(i), 2'b10});
    end
    end_samples();
    chk("s6_fill", int'(fill_out), 4);
    chk("s6_busy", int'(busy_out), 1);
    #2 sys_reset_out = 1'b1;
    #1;
    chk("s6_arst_data", int'(data_out), 0);
    chk("s6_arst_empty", int'(empty_out), 1);
    chk("s6_arst_fill", int'(fill_out), 0);
    chk("s6_arst_ovf", int'(overflow_out), 0);
    chk("s6_arst_done", int'(done_out), 0);
    chk("s6_arst_busy", int'(busy_out), 0);
    exp_q.delete();
    chan_sel_in = 3'd3; mode_in = 1'b0; block_len_in = '0;
    repeat (2) tick();
    sys_reset_out = 1'b0;
    repeat (3) tick();
    arm();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'h7000 + 16'(i));
      drive_sample(3, {16'h7000 + 16'(i), 2'b11});
    end
    end_samples();
    chk("s6_post_fill", int'(fill_out), 3);
    chk("s6_post_head", int'(data_out), 16'h7000);
    drain("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osf_stream_capture.md
Name: osf_stream_capture

Overview:
Parametrised capture engine for the oversample-filter output stream. It selects one of N_CH filtered ADC channels and decimates that channel's valid samples. The samples are written into an internal FIFO, in either continuous or single-shot block mode, and the host read path drains the FIFO. It sits between the oversample filters and the host pipe endpoint. Compared with the fixed single-channel pipe FIFO path, it adds decimation, block capture, overflow accounting and automatic flush on channel or mode change.

Parameters:
N_CH, 8, number of oversample-filter channels
W_DATA, 18, width of each filtered sample
W_OUT, 16, width of the FIFO word; the top W_OUT bits of the sample are stored
DEPTH, 1024, FIFO depth in words; must be a power of two, at least 4
W_DEC, 16, width of the decimation ratio
W_CNT, $clog2(DEPTH)+1, width of the fill count and block length

Ports:
clk50_in  in  1  system clock
sys_reset_out  in  1  system reset; asynchronous, active-high
data_valid_in  in  N_CH  per-channel sample-valid strobes
data_packed_in  in  N_CH*W_DATA  packed samples; channel k at [k*W_DATA +: W_DATA]
chan_sel_in  in  $clog2(N_CH)  channel to capture (level)
mode_in  in  1  0 = continuous, 1 = single-shot block (level)
decim_in  in  W_DEC  keep 1 of every decim_in+1 valid samples (level)
block_len_in  in  W_CNT  words per block in mode 1; 0 is treated as DEPTH
arm_in  in  1  one-cycle pulse: start capture
rd_en_in  in  1  pop one word; ignored while empty
data_out  out  W_OUT  FIFO head word (first-word-fall-through)
empty_out  out  1  FIFO empty
fill_out  out  W_CNT  words currently stored, 0..DEPTH
overflow_out  out  1  sticky; set when a kept sample is dropped because the FIFO is full
done_out  out  1  level; high in DONE state
busy_out  out  1  high in CAPTURE state

Behaviour:
- Reset values: data_out=0, empty_out=1, fill_out=0, overflow_out=0, done_out=0, busy_out=0. The FIFO pointers, decimation counter and block counter clear to 0, and the FSM enters IDLE.
- The clock is clk50_in. Reset is sys_reset_out, asynchronous and active-high. Reset mid-capture discards all stored data immediately.
- Input register: sel_valid = data_valid_in[chan_sel_in] and sel_data = top W_OUT bits of the selected sample are registered once. A sample is written at most 2 cycles after its valid strobe.
- Decimation counter dcnt:
  - on each registered valid in CAPTURE: if dcnt==0 the sample is kept, else it is skipped;
  - then dcnt <= (dcnt==decim_in) ? 0 : dcnt+1;
  - decim_in=0 keeps every sample; the first valid after arm is always kept.
- FSM states:
  - IDLE: no writes. arm_in moves to CAPTURE and clears dcnt, the block counter and overflow_out. The FIFO is not flushed on arm.
  - CAPTURE, mode 0: keep writing until the next arm_in. A repeated arm restarts the counters and clears overflow_out, and the FSM stays in CAPTURE.
  - CAPTURE, mode 1: each accepted write increments the block counter. When it reaches block_len_in (0 means DEPTH), go to DONE. Kept samples dropped on full do not count toward the block, and they set overflow_out.
  - DONE: done_out=1, no writes. arm_in returns to CAPTURE with counters cleared.
- Flush: any change of chan_sel_in or mode_in, detected against a registered copy, does all of the following in the cycle after the change:
  - empties the FIFO;
  - clears dcnt, the block counter and overflow_out;
  - forces IDLE.
  - Flush has priority over arm_in, writes and reads in that cycle.
- FIFO:
  - RAM-based, DEPTH words, pointers of W_CNT bits; full when the pointers differ only in the MSB.
  - data_out shows the head word whenever empty_out=0.
  - A pop on rd_en_in takes effect at the clock edge, and the next word is visible on the following cycle.
  - fill_out updates in the same cycle as the pointers.
- Simultaneous events:
  - Read and write in the same cycle when full: both happen, the write is accepted, no overflow, fill stays at DEPTH.
  - Read and write when empty: only the write takes effect, empty_out drops the next cycle.
  - rd_en_in while empty is ignored, with no underflow flag.
  - arm_in and the final block write in the same cycle: the write completes and the FSM restarts in CAPTURE.
- Decimation and block-length inputs are sampled live. Changing them mid-capture affects subsequent samples only, with no flush.

Test Plan:
1. Reset, then arm with mode 0, chan_sel=3, decim=0. Drive 10 valid samples on channel 3 (values 0x3FFFF down) and noise on the others -> fill_out=10, and reading returns the top 16 bits in order (0xFFFF first).
2. Mode 1, block_len=5, decim=2, 20 valids -> kept samples are #0,3,6,9,12 only; done_out rises after the 5th write; fill_out=5; later valids are ignored.
3. Mode 0, DEPTH=16, 20 kept samples with no reads -> fill_out=16, overflow_out=1, and the first 16 samples read back intact. Re-arming clears overflow_out.
4. FIFO full, with rd_en_in and a kept sample in the same cycle -> fill_out stays 16, no overflow, and the new word appears at the tail.
5. Change chan_sel mid-capture with 7 words stored -> next cycle fill_out=0, empty_out=1, busy_out=0; arm resumes capture on the new channel.
6. Assert sys_reset_out asynchronously mid-block -> all outputs return to reset values without a clock edge, and the first arm after release behaves as in scenario 1.
